// File: rtl/vmem_pkg.sv
// Shared definitions for the RGB444 video memory: geometry, address/pixel types, writer FSM states.
// Used by the write master and the display read path.
package vmem_pkg;
    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int ADDR_W    = 19;
    localparam int PIX_W     = 12;
    localparam int FRAME_PIX = H_RES * V_RES;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] vaddr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/vmem_addr_calc.sv
// Combinational (x,y) -> linear video address, y*640 built as (y<<9)+(y<<7) plus x.
// Out-of-range coordinates wrap to ADDR_W bits.
module vmem_addr_calc
    import vmem_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    output vaddr_t     addr
);
    // 20 bits holds the largest possible sum, 1023*640+1023.
    logic [19:0] full_sum;

    always_comb begin
        full_sum = {1'b0, y, 9'b0} + {3'b0, y, 7'b0} + {10'b0, x};
        addr     = full_sum[ADDR_W-1:0];
    end
endmodule

// File: rtl/vmem_writer.sv
// Write-side master for the video RAM: pixel writes over valid/ready plus a full-frame clear sweep.
// Optional VMEM_WR_BOUNDS_EN drops off-screen pixels and flags them on a sticky oob_err output.
module vmem_writer #(
    parameter int V_RES = vmem_pkg::V_RES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_x,
    input  logic [9:0]       in_y,
    input  vmem_pkg::pix_t   in_data,
    input  logic             clr_start,
    input  vmem_pkg::pix_t   clr_color,
    output logic             busy,
    output logic             clr_done,
    output vmem_pkg::vaddr_t wr_addr,
    output vmem_pkg::pix_t   wr_data,
    output logic             wr_en,
`ifdef VMEM_WR_BOUNDS_EN
    output logic             oob_err,
`endif
    output vmem_pkg::state_t dbg_state
);
    import vmem_pkg::*;

    // Handshake: a pixel transfers on any rising edge where in_valid and in_ready are both 1;
    // in_ready is registered and depends only on state, never on in_valid.
    // The line pitch is fixed at 640 by the shift-add; V_RES only sets the sweep length.
    localparam vaddr_t FRAME_END = vaddr_t'(H_RES * V_RES);

    state_t state_q, state_d;
    vaddr_t cnt_q, cnt_d;
    vaddr_t wr_addr_q, wr_addr_d;
    pix_t   wr_data_q, wr_data_d;
    pix_t   color_q, color_d;
    logic   wr_en_q, wr_en_d;
    logic   busy_q, busy_d;
    logic   clr_done_q, clr_done_d;
    logic   in_ready_q, in_ready_d;
    logic   oob_q, oob_d;
    logic   accept;
    logic   pix_ok;
    vaddr_t pix_addr;

    vmem_addr_calc u_addr_calc (
        .x    (in_x),
        .y    (in_y),
        .addr (pix_addr)
    );

`ifdef VMEM_WR_BOUNDS_EN
    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);
    assign pix_ok  = (in_x < H_LIM) && (in_y < V_LIM);
    assign oob_err = oob_q;
`else
    assign pix_ok = 1'b1;
`endif

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        color_d    = color_q;
        wr_en_d    = 1'b0;
        clr_done_d = 1'b0;
        oob_d      = oob_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    oob_d = 1'b0;
                end
                if (accept && pix_ok) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = in_data;
                end else if (accept) begin
                    oob_d = 1'b1;
                end
                // A pixel accepted alongside clr_start still writes; the sweep follows next cycle.
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clr_color;
                end
            end
            CLEAR: begin
                if (cnt_q == FRAME_END) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = color_q;
                    cnt_d     = cnt_q + vaddr_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d == CLEAR);
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            color_q    <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            in_ready_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            color_q    <= color_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            in_ready_q <= in_ready_d;
            oob_q      <= oob_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign clr_done  = clr_done_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_vmem_writer.sv
// Bench for vmem_writer with a short frame (4 lines) so clear sweeps stay brief.
// Honours VMEM_WR_BOUNDS_EN in the same way as the design.
module tb_vmem_writer;
    import vmem_pkg::*;

    localparam int TB_V = 4;
    localparam int F    = 640 * TB_V;
    localparam int NV   = 8;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid;
    logic   in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;
    pix_t   in_data;
    logic   clr_start;
    pix_t   clr_color;
    logic   busy;
    logic   clr_done;
    vaddr_t wr_addr;
    pix_t   wr_data;
    logic   wr_en;
    logic   oob_a;
    state_t dbg_state;

    always #5 clk = ~clk;

    vmem_writer #(.V_RES(TB_V)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_data   (in_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
`ifdef VMEM_WR_BOUNDS_EN
        .oob_err   (oob_a),
`endif
        .dbg_state (dbg_state)
    );

`ifndef VMEM_WR_BOUNDS_EN
    assign oob_a = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected visible outputs for the current cycle plus clear progress.
    logic   m_en, m_busy, m_done, m_ready, m_oob;
    vaddr_t m_addr;
    pix_t   m_data, m_color;
    int     clr_k;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        pix_t       d;
        vaddr_t     exp_addr;
    } vec_t;
    vec_t vecs[NV];

    function automatic logic tb_oob(input logic [9:0] x, input logic [9:0] y);
`ifdef VMEM_WR_BOUNDS_EN
        return (x >= 10'd640) || (y >= 10'(TB_V));
`else
        return 1'b0;
`endif
    endfunction

    function automatic vaddr_t ref_addr(input logic [9:0] x, input logic [9:0] y);
        return vaddr_t'(int'(y) * 640 + int'(x));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] a;
        logic [63:0] e;
        a = {28'b0, wr_en, wr_addr, wr_data, busy, clr_done, in_ready, oob_a};
        e = {28'b0, m_en, m_addr, m_data, m_busy, m_done, m_ready, m_oob};
        check("outputs{en,addr,data,busy,done,ready,oob}", a, e);
    endtask

    task automatic model_reset();
        m_en = 0; m_addr = '0; m_data = '0; m_busy = 0; m_done = 0;
        m_ready = 0; m_oob = 0; m_color = '0; clr_k = 0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [9:0] x,
                              input logic [9:0] y, input pix_t d, input logic cs, input pix_t cc);
        logic acc;
        if (r) begin
            model_reset();
        end else begin
            acc    = v && m_ready;
            m_en   = 1'b0;
            m_done = 1'b0;
            if (clr_k > 0) begin
                clr_k++;
                if (clr_k <= F + 1) begin
                    m_en   = 1'b1;
                    m_addr = vaddr_t'(clr_k - 2);
                    m_data = m_color;
                end else begin
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                    clr_k   = 0;
                end
            end else begin
                if (cs) m_oob = 1'b0;
                if (acc) begin
                    if (tb_oob(x, y)) begin
                        m_oob = 1'b1;
                    end else begin
                        m_en   = 1'b1;
                        m_addr = ref_addr(x, y);
                        m_data = d;
                    end
                end
                if (cs) begin
                    clr_k   = 1;
                    m_busy  = 1'b1;
                    m_ready = 1'b0;
                    m_color = cc;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic r, input logic v, input logic [9:0] x, input logic [9:0] y,
                         input pix_t d, input logic cs, input pix_t cc);
        model_step(r, v, x, y, d, cs, cc);
        rst = r; in_valid = v; in_x = x; in_y = y; in_data = d;
        clr_start = cs; clr_color = cc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'd0, 10'd0, '0, 1'b0, '0);
    endtask

    initial begin
        vaddr_t last_addr;
        int n_wr;
        int n_done;

        vecs[0] = '{10'd3,    10'd2,    12'hF00, vaddr_t'(1283)};
        vecs[1] = '{10'd0,    10'd0,    12'h0A5, vaddr_t'(0)};
        vecs[2] = '{10'd639,  10'd479,  12'hFFF, vaddr_t'(307199)};
        vecs[3] = '{10'd639,  10'd0,    12'h123, vaddr_t'(639)};
        vecs[4] = '{10'd0,    10'd1,    12'h456, vaddr_t'(640)};
        vecs[5] = '{10'd5,    10'd0,    12'h789, vaddr_t'(5)};
        vecs[6] = '{10'd320,  10'd240,  12'hABC, vaddr_t'(153920)};
        vecs[7] = '{10'd1023, 10'd1023, 12'hF0F, vaddr_t'(131455)};

        rst = 1; in_valid = 0; in_x = '0; in_y = '0; in_data = '0;
        clr_start = 0; clr_color = '0;
        model_reset();
        @(posedge clk);

        // Reset values, then in_ready rises one cycle after rst drops.
        sample();
        check("rst_wr_en", {63'b0, wr_en}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        drive(1'b1, 1'b0, 10'd0, 10'd0, '0, 1'b0, '0);
        sample();
        idle();
        sample();
        check("ready_after_rst", {63'b0, in_ready}, 64'd1);
        idle();

        // Table of back-to-back single pixels.
        last_addr = '0;
        for (int i = 0; i <= NV; i++) begin
            sample();
            if (i > 0) begin
                if (!tb_oob(vecs[i-1].x, vecs[i-1].y)) begin
                    check($sformatf("vec%0d_en", i-1), {63'b0, wr_en}, 64'd1);
                    check($sformatf("vec%0d_addr", i-1), 64'(wr_addr), 64'(vecs[i-1].exp_addr));
                    check($sformatf("vec%0d_data", i-1), 64'(wr_data), 64'(vecs[i-1].d));
                    last_addr = vecs[i-1].exp_addr;
                end else begin
                    check($sformatf("vec%0d_en_oob", i-1), {63'b0, wr_en}, 64'd0);
                    check($sformatf("vec%0d_addr_hold", i-1), 64'(wr_addr), 64'(last_addr));
                end
            end
            if (i < NV) drive(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].d, 1'b0, '0);
            else idle();
        end

        // Full clear sweep while a master keeps offering pixels.
        sample();
        drive(1'b0, 1'b0, 10'd0, 10'd0, '0, 1'b1, 12'h00F);
        n_wr = 0; n_done = 0;
        for (int k = 0; k < F + 3; k++) begin
            sample();
            if (wr_en && busy) n_wr++;
            if (clr_done) n_done++;
            drive(1'b0, 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, TB_V - 1)),
                  pix_t'($urandom), 1'b0, '0);
        end
        check("clr_write_count", 64'(n_wr), 64'(F));
        check("clr_done_pulses", 64'(n_done), 64'd1);

        // Pixel and clr_start in the same cycle: pixel first, then sweep from 0.
        sample();
        idle();
        sample();
        drive(1'b0, 1'b1, 10'd5, 10'd0, 12'h3C3, 1'b1, 12'h0F0);
        sample();
        check("same_cycle_pix_addr", 64'(wr_addr), 64'd5);
        check("same_cycle_pix_en", {63'b0, wr_en}, 64'd1);
        drive(1'b0, 1'b0, 10'd0, 10'd0, '0, 1'b1, 12'hAAA);
        sample();
        check("sweep_first_addr", 64'(wr_addr), 64'd0);
        check("sweep_first_data", 64'(wr_data), 64'h0F0);
        for (int k = 0; k < F + 2; k++) begin
            idle();
            sample();
        end

        // Reset in the middle of a sweep.
        drive(1'b0, 1'b0, 10'd0, 10'd0, '0, 1'b1, 12'h777);
        for (int j = 1; j <= 1002; j++) begin
            sample();
            if (j < 1002) idle();
        end
        check("mid_sweep_addr", 64'(wr_addr), 64'd1000);
        drive(1'b1, 1'b0, 10'd0, 10'd0, '0, 1'b0, '0);
        sample();
        check("abort_wr_en", {63'b0, wr_en}, 64'd0);
        check("abort_busy", {63'b0, busy}, 64'd0);
        idle();
        sample();
        check("abort_ready", {63'b0, in_ready}, 64'd1);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            sample();
            if (clr_done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);

`ifdef VMEM_WR_BOUNDS_EN
        check("oob_ready", {63'b0, in_ready}, 64'd1);
        drive(1'b0, 1'b1, 10'd640, 10'd0, 12'h111, 1'b0, '0);
        sample();
        check("oob_no_write", {63'b0, wr_en}, 64'd0);
        check("oob_flag", {63'b0, oob_a}, 64'd1);
        idle();
        sample();
        check("oob_sticky", {63'b0, oob_a}, 64'd1);
        drive(1'b0, 1'b0, 10'd0, 10'd0, '0, 1'b1, 12'h000);
        sample();
        check("oob_cleared", {63'b0, oob_a}, 64'd0);
        for (int k = 0; k < F + 2; k++) begin
            idle();
            sample();
        end
`endif

        // Randomised traffic with occasional clears and resets.
        idle();
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic cs;
            logic [9:0] x;
            logic [9:0] y;
            sample();
            r  = ($urandom_range(0, 199) == 0);
            cs = (n == 100) || ($urandom_range(0, 299) == 0);
            x  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
            y  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
            drive(r, 1'($urandom_range(0, 1)), x, y, pix_t'($urandom), cs, pix_t'($urandom));
        end
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
